pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. It merges stall requests from IF, ID, EX and MEM into the 6-bit `stall` vector that every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb) consumes. It also raises `flush` and `new_pc` when MEM commits an exception. An exception reported while MEM is stalled on the bus is latched and replayed when the stall releases. The block also keeps stall and flush performance counters.

## Interface
Parameters:
- EXC_VECTOR, 32'h00000020, PC loaded for every exception except ERET
- CNT_W, 32, performance-counter width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stallreq_from_if  in  1  instruction-bus wait
- stallreq_from_id  in  1  load-use hazard
- stallreq_from_ex  in  1  multi-cycle op (div, madd/msub)
- stallreq_from_mem  in  1  data-bus wait
- excepttype_i  in  32  exception code from MEM stage; 0 = none
- cp0_epc_i  in  32  current EPC from CP0
- cnt_clr  in  1  synchronous clear of both counters
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop
- flush  out  1  flush all pipeline registers this cycle
- new_pc  out  32  redirect target, valid while flush=1
- exc_pending  out  1  an exception is latched behind a MEM stall
- stall_cnt  out  CNT_W  cycles with stall[0]=1
- flush_cnt  out  CNT_W  flush pulses issued

## Operation
- FSM states: RUN and HOLD.
- Stall encoding, priority MEM > EX > ID > IF:
  - MEM request → 6'b011111
  - EX request → 6'b001111
  - ID request → 6'b000111
  - IF request → 6'b000111
  - none → 6'b000000
- RUN, excepttype_i≠0 and stallreq_from_mem=0:
  - flush=1 and stall=0 this cycle.
  - new_pc = cp0_epc_i when excepttype_i=32'h0000000e (ERET); otherwise EXC_VECTOR.
- RUN, excepttype_i≠0 and stallreq_from_mem=1:
  - Latch the type-derived target (ERET → cp0_epc_i sampled now; otherwise EXC_VECTOR) and enter HOLD.
  - No flush this cycle; stall=011111.
- HOLD:
  - exc_pending=1 and stall=011111 while stallreq_from_mem=1.
  - New excepttype_i values are ignored.
  - When stallreq_from_mem=0: flush=1, new_pc = latched target, stall=0, return to RUN.
- flush always forces stall=6'b000000.
- new_pc=0 whenever flush=0.
- stall_cnt increments every cycle stall[0]=1; flush_cnt increments every cycle flush=1.
- Both counters saturate at all-ones.
- cnt_clr zeroes both counters and takes priority over increment.

## Timing
- stall, flush and new_pc are combinational from the current inputs and state. Pipeline registers act on them at the next clk edge (zero-cycle control latency).
- The HOLD→RUN flush is asserted in the same cycle stallreq_from_mem drops. The exception is never lost and never issued twice.
- rst (sampled on posedge clk):
  - state=RUN, latched target=0, counters=0.
  - While rst=1, stall=0, flush=0, new_pc=0, exc_pending=0.
- Reset during HOLD discards the pending exception; no flush is issued.
- An exception arriving in the same cycle as an EX/ID stall request: flush wins and stall=0.
- cnt_clr in the same cycle as an increment: the counter reads 0 after the edge.
- A stall request asserted for N consecutive cycles adds exactly N to stall_cnt.

## Structure
- Stall-mask constants (STALL_MEM, STALL_EX, STALL_ID, STALL_NONE), ERET code 32'h0000000e, Stop/NoStop, and the FSM state encoding go in defines.v with the existing macros.
- One natural sub-module: `sat_counter` (parameter width; inputs inc and clr), instantiated twice.
- FSM, latch and stall mux stay in pipe_ctrl.

## Test plan
- stallreq_from_ex=1 for 3 cycles → stall=001111 for exactly those cycles; stall_cnt=3.
- stallreq_from_id=1 and stallreq_from_mem=1 together → stall=011111.
- excepttype_i=32'h0000000c, no stalls → flush=1 the same cycle, new_pc=32'h00000020, stall=0, flush_cnt=1.
- ERET exception with cp0_epc_i=32'h00400010 while stallreq_from_mem=1 for 4 cycles (cp0_epc_i changed after the first cycle):
  - exc_pending=1 for those 4 cycles.
  - Then flush=1 for exactly 1 cycle with new_pc=32'h00400010.
- rst in HOLD → no flush afterwards; all outputs 0.
- With stall_cnt preloaded to near-max by a long stall run: saturates at all-ones; cnt_clr → 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : pipe_ctrl_pkg
// Description : Stall masks, exception codes, FSM states and helpers for
//               pipe_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

    localparam logic        c_stop        = 1'b1;
    localparam logic        c_no_stop     = 1'b0;

    // stall[0]=PC ... stall[5]=WB
    localparam logic [5:0]  c_stall_mem   = 6'b011111;
    localparam logic [5:0]  c_stall_ex    = 6'b001111;
    localparam logic [5:0]  c_stall_id    = 6'b000111;
    localparam logic [5:0]  c_stall_none  = 6'b000000;

    localparam logic [31:0] c_exc_none    = 32'h00000000;
    localparam logic [31:0] c_eret_code   = 32'h0000000e;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic [5:0] stall_mask(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        if (req_mem)
            return c_stall_mem;
        else if (req_ex)
            return c_stall_ex;
        else if (req_id || req_if)
            return c_stall_id;
        else
            return c_stall_none;
    endfunction

    function automatic logic [31:0] exc_target(
        input logic [31:0] excepttype,
        input logic [31:0] epc,
        input logic [31:0] vector
    );
        return (excepttype == c_eret_code) ? epc : vector;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
//------------------------------------------------------------------------------
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; clear beats increment.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_count <= '0;
        else if (i_inc && (r_count != {WIDTH{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pipe_ctrl
// Description : Merges stage stall requests, issues exception flushes and
//               replays exceptions held behind a MEM bus stall.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             cnt_clr,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             exc_pending,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t      r_state;
    logic [31:0] r_target;

    logic [5:0]  w_stall;
    logic        w_flush;
    logic [31:0] w_new_pc;
    logic        w_pending;
    logic        w_latch;

    // Outputs are forced quiet while rst is high, independent of state.
    always_comb begin
        w_stall   = c_stall_none;
        w_flush   = 1'b0;
        w_new_pc  = 32'h0;
        w_pending = 1'b0;
        w_latch   = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (excepttype_i != c_exc_none) begin
                        if (stallreq_from_mem) begin
                            w_stall   = c_stall_mem;
                            w_pending = 1'b1;
                            w_latch   = 1'b1;
                        end else begin
                            w_flush  = 1'b1;
                            w_new_pc = exc_target(excepttype_i, cp0_epc_i, EXC_VECTOR);
                        end
                    end else begin
                        w_stall = stall_mask(stallreq_from_if, stallreq_from_id,
                                             stallreq_from_ex, stallreq_from_mem);
                    end
                end
                ST_HOLD: begin
                    if (stallreq_from_mem) begin
                        w_stall   = c_stall_mem;
                        w_pending = 1'b1;
                    end else begin
                        w_flush  = 1'b1;
                        w_new_pc = r_target;
                    end
                end
                default: begin
                    w_stall = c_stall_none;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_target <= 32'h0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_latch) begin
                        r_target <= exc_target(excepttype_i, cp0_epc_i, EXC_VECTOR);
                        r_state  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stallreq_from_mem)
                        r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign stall       = w_stall;
    assign flush       = w_flush;
    assign new_pc      = w_new_pc;
    assign exc_pending = w_pending;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (cnt_clr),
        .i_inc   (w_stall[0] == c_stop),
        .o_count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (cnt_clr),
        .i_inc   (w_flush),
        .o_count (flush_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl (vector table, directed
//               sequences, random traffic against a behavioural model).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_ctrl;

    localparam int          CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] VEC     = 32'h00000020;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_if, req_id, req_ex, req_mem;
    logic [31:0]      exc, epc;
    logic             cnt_clr;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             exc_pending;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: an optional pending redirect plus two counts.
    bit          m_has_pending;
    logic [31:0] m_target;
    int          m_scnt;
    int          m_fcnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.EXC_VECTOR(VEC), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (req_if),
        .stallreq_from_id  (req_id),
        .stallreq_from_ex  (req_ex),
        .stallreq_from_mem (req_mem),
        .excepttype_i      (exc),
        .cp0_epc_i         (epc),
        .cnt_clr           (cnt_clr),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .exc_pending       (exc_pending),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_comb(output logic [5:0] s, output logic f,
                              output logic [31:0] pc, output logic p);
        s = 6'b0; f = 1'b0; pc = 32'h0; p = 1'b0;
        if (!rst) begin
            if (m_has_pending || exc != 0) begin
                if (req_mem) begin
                    s = 6'b011111;
                    p = 1'b1;
                end else begin
                    f  = 1'b1;
                    pc = m_has_pending ? m_target : ((exc == 32'he) ? epc : VEC);
                end
            end else if (req_mem) s = 6'b011111;
            else if (req_ex)      s = 6'b001111;
            else if (req_id || req_if) s = 6'b000111;
        end
    endtask

    task automatic model_edge(input logic [5:0] s, input logic f);
        if (rst) begin
            m_has_pending = 0;
            m_target      = 0;
            m_scnt        = 0;
            m_fcnt        = 0;
        end else begin
            if (cnt_clr) begin
                m_scnt = 0;
                m_fcnt = 0;
            end else begin
                if (s[0] && m_scnt < CNT_MAX) m_scnt++;
                if (f && m_fcnt < CNT_MAX)    m_fcnt++;
            end
            if (m_has_pending) begin
                if (!req_mem) m_has_pending = 0;
            end else if (exc != 0 && req_mem) begin
                m_has_pending = 1;
                m_target      = (exc == 32'he) ? epc : VEC;
            end
        end
    endtask

    // Called just after a posedge with inputs already driven.
    task automatic cycle();
        logic [5:0]  es;
        logic        ef;
        logic [31:0] epc_e;
        logic        ep;
        #1;
        model_comb(es, ef, epc_e, ep);
        check("stall",       {26'b0, stall},       {26'b0, es});
        check("flush",       {31'b0, flush},       {31'b0, ef});
        check("new_pc",      new_pc,               epc_e);
        check("exc_pending", {31'b0, exc_pending}, {31'b0, ep});
        check("stall_cnt",   {24'b0, stall_cnt},   m_scnt);
        check("flush_cnt",   {24'b0, flush_cnt},   m_fcnt);
        @(posedge clk);
        model_edge(es, ef);
        #1;
    endtask

    task automatic idle();
        rst = 0; req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
        exc = 0; epc = 0; cnt_clr = 0;
    endtask

    typedef struct {
        logic        rst, sif, sid, sex, smem;
        logic [31:0] exc, epc;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        pend;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{1, 0, 1, 0, 1, 32'h0c, 32'h0,     6'b000000, 0, 32'h0,     0};
        vt[1]  = '{0, 0, 0, 0, 0, 32'h00, 32'h0,     6'b000000, 0, 32'h0,     0};
        vt[2]  = '{0, 1, 0, 0, 0, 32'h00, 32'h0,     6'b000111, 0, 32'h0,     0};
        vt[3]  = '{0, 0, 1, 0, 0, 32'h00, 32'h0,     6'b000111, 0, 32'h0,     0};
        vt[4]  = '{0, 0, 0, 1, 0, 32'h00, 32'h0,     6'b001111, 0, 32'h0,     0};
        vt[5]  = '{0, 0, 0, 0, 1, 32'h00, 32'h0,     6'b011111, 0, 32'h0,     0};
        vt[6]  = '{0, 0, 1, 0, 1, 32'h00, 32'h0,     6'b011111, 0, 32'h0,     0};
        vt[7]  = '{0, 0, 0, 0, 0, 32'h0c, 32'h0,     6'b000000, 1, 32'h20,    0};
        vt[8]  = '{0, 1, 1, 1, 0, 32'h0c, 32'h0,     6'b000000, 1, 32'h20,    0};
        vt[9]  = '{0, 0, 0, 0, 0, 32'h0e, 32'h1234,  6'b000000, 1, 32'h1234,  0};
        vt[10] = '{0, 1, 0, 1, 0, 32'h00, 32'h0,     6'b001111, 0, 32'h0,     0};

        idle();
        rst = 1;
        m_has_pending = 0; m_target = 0; m_scnt = 0; m_fcnt = 0;
        @(posedge clk); #1;
        cycle();
        check("reset_stall_cnt", {24'b0, stall_cnt}, 32'd0);
        check("reset_flush_cnt", {24'b0, flush_cnt}, 32'd0);

        // Single-cycle vectors from RUN
        for (int i = 0; i < 11; i++) begin
            rst = vt[i].rst; req_if = vt[i].sif; req_id = vt[i].sid;
            req_ex = vt[i].sex; req_mem = vt[i].smem; exc = vt[i].exc; epc = vt[i].epc;
            #1;
            check($sformatf("vec%0d_stall", i), {26'b0, stall}, {26'b0, vt[i].st});
            check($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vt[i].fl});
            check($sformatf("vec%0d_pc", i), new_pc, vt[i].pc);
            check($sformatf("vec%0d_pend", i), {31'b0, exc_pending}, {31'b0, vt[i].pend});
            cycle();
        end
        idle();
        #1;
        check("table_stall_cnt", {24'b0, stall_cnt}, 32'd6);
        check("table_flush_cnt", {24'b0, flush_cnt}, 32'd3);
        cycle();

        // EX stall for exactly 3 cycles
        cnt_clr = 1; cycle(); cnt_clr = 0;
        req_ex = 1;
        for (int i = 0; i < 3; i++) begin
            #1; check("ex3_stall", {26'b0, stall}, 32'h0f);
            cycle();
        end
        req_ex = 0;
        #1;
        check("ex3_stall_off", {26'b0, stall}, 32'h0);
        check("ex3_stall_cnt", {24'b0, stall_cnt}, 32'd3);
        cycle();

        // ERET behind 4-cycle MEM stall; EPC changes after the first cycle
        exc = 32'he; epc = 32'h00400010; req_mem = 1;
        for (int i = 0; i < 4; i++) begin
            #1; check("eret_pending", {31'b0, exc_pending}, 32'd1);
            check("eret_noflush", {31'b0, flush}, 32'd0);
            cycle();
            exc = (i == 1) ? 32'h0c : 32'h0; epc = 32'hdeadbeef;
        end
        req_mem = 0; exc = 0;
        #1;
        check("eret_flush", {31'b0, flush}, 32'd1);
        check("eret_pc", new_pc, 32'h00400010);
        check("eret_stall", {26'b0, stall}, 32'h0);
        cycle();
        #1;
        check("eret_once", {31'b0, flush}, 32'd0);
        cycle();

        // Reset while HOLD drops the pending exception
        exc = 32'h0c; req_mem = 1; cycle();
        exc = 0; cycle();
        rst = 1;
        #1;
        check("rst_hold_stall", {26'b0, stall}, 32'h0);
        check("rst_hold_pend", {31'b0, exc_pending}, 32'd0);
        cycle();
        rst = 0; req_mem = 0;
        #1;
        check("rst_hold_noflush", {31'b0, flush}, 32'd0);
        check("rst_hold_pc", new_pc, 32'h0);
        check("rst_hold_cnt", {24'b0, stall_cnt}, 32'd0);
        cycle();

        // Saturation, then clear concurrent with increment
        req_mem = 1;
        for (int i = 0; i < CNT_MAX + 5; i++) cycle();
        #1; check("sat_stall_cnt", {24'b0, stall_cnt}, CNT_MAX);
        cnt_clr = 1; cycle();
        cnt_clr = 0; req_mem = 0;
        #1; check("clr_stall_cnt", {24'b0, stall_cnt}, 32'd0);
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            req_if  = ($urandom_range(0, 3) == 0);
            req_id  = ($urandom_range(0, 3) == 0);
            req_ex  = ($urandom_range(0, 3) == 0);
            req_mem = ($urandom_range(0, 2) == 0);
            epc     = $urandom;
            case ($urandom_range(0, 15))
                0:       exc = 32'h0c;
                1:       exc = 32'h0e;
                2:       exc = $urandom | 32'h1;
                default: exc = 32'h0;
            endcase
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
